// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller: command codes, frame geometry,
// FSM state encodings and the frame builder used by both RTL and bench monitors.
package spi_pkg;

    localparam int FRAME_W = 11;
    localparam int DATA_W  = 8;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_WR_ADDR = 2'b00;
    localparam cmd_t CMD_WR_DATA = 2'b01;
    localparam cmd_t CMD_RD_ADDR = 2'b10;
    localparam cmd_t CMD_RD_DATA = 2'b11;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SHIFT_OUT = 3'd1;
    localparam logic [2:0] ST_WAIT_RD   = 3'd2;
    localparam logic [2:0] ST_SHIFT_IN  = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    // Bit 10 duplicates the rd/wr flag so the slave can decide direction on the first bit.
    function automatic logic [FRAME_W-1:0] build_frame(input cmd_t cmd_type,
                                                       input logic [DATA_W-1:0] cmd_data);
        return {cmd_type[1], cmd_type, cmd_data};
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side command/read-data bus of the SPI master controller.
interface spi_master_ctrl_if;
    import spi_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    cmd_t              cmd_type;
    logic [DATA_W-1:0] cmd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    modport slave  (input  cmd_valid, cmd_type, cmd_data,
                    output cmd_ready, rd_valid, rd_data, busy);
    modport master (output cmd_valid, cmd_type, cmd_data,
                    input  cmd_ready, rd_valid, rd_data, busy);

endinterface

// File: rtl/spi_shreg.sv
// Parallel-load, MSB-first serial shift register; load has priority over shift.
module spi_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    input  logic         ser_in,
    output logic [W-1:0] q
);

    // Shift register state
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= {W{1'b0}};
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {q[W-2:0], ser_in};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises 11-bit RAM command frames on MOSI/SS_n and collects
// the 8-bit read-data reply on MISO for rd-data commands.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_ctrl_if.slave   host,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    localparam logic [3:0] OUT_LAST  = 4'(FRAME_W - 1);
    localparam logic [3:0] IN_LAST   = 4'(DATA_W - 1);
    localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    logic [2:0]         state_r;
    logic [3:0]         cnt_r;
    cmd_t               cmd_type_r;
    logic               ss_n_r;
    logic               cmd_ready_r;
    logic               busy_r;
    logic               rd_valid_r;
    logic [DATA_W-1:0]  rd_data_r;

    logic               accept_s;
    logic               illegal_s;
    logic               out_load_s;
    logic [FRAME_W-1:0] out_val_s;
    logic               out_shift_s;
    logic               in_load_s;
    logic               in_shift_s;
    logic [FRAME_W-1:0] out_q_s;
    logic [DATA_W-1:0]  in_q_s;
    logic               unused_bits_s;

    assign accept_s  = (state_r == ST_IDLE) && cmd_ready_r && host.cmd_valid;
    assign illegal_s = (state_r > ST_GAP);

    // Shift-register control; the output register is zero-filled so MOSI idles low
    always_comb begin
        out_load_s  = 1'b0;
        out_val_s   = {FRAME_W{1'b0}};
        out_shift_s = 1'b0;
        in_load_s   = 1'b0;
        in_shift_s  = 1'b0;
        if (accept_s) begin
            out_load_s = 1'b1;
            out_val_s  = build_frame(host.cmd_type, host.cmd_data);
            in_load_s  = 1'b1;
        end else if (illegal_s) begin
            out_load_s = 1'b1;
            in_load_s  = 1'b1;
        end else begin
            out_shift_s = (state_r == ST_SHIFT_OUT);
            in_shift_s  = (state_r == ST_SHIFT_IN);
        end
    end

    spi_shreg #(.W(FRAME_W)) u_out_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (out_load_s),
        .load_val (out_val_s),
        .shift_en (out_shift_s),
        .ser_in   (1'b0),
        .q        (out_q_s)
    );

    spi_shreg #(.W(DATA_W)) u_in_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (in_load_s),
        .load_val ({DATA_W{1'b0}}),
        .shift_en (in_shift_s),
        .ser_in   (MISO),
        .q        (in_q_s)
    );

    // Frame sequencing FSM and registered host/SPI outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            cmd_type_r  <= CMD_WR_ADDR;
            ss_n_r      <= 1'b1;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= {DATA_W{1'b0}};
        end else begin
            rd_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cmd_type_r  <= host.cmd_type;
                        ss_n_r      <= 1'b0;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        cnt_r       <= 4'd0;
                        state_r     <= ST_SHIFT_OUT;
                    end
                end
                ST_SHIFT_OUT: begin
                    if (cnt_r == OUT_LAST) begin
                        cnt_r <= 4'd0;
                        if (cmd_type_r == CMD_RD_DATA) begin
                            state_r <= (RD_LATENCY == 0) ? ST_SHIFT_IN : ST_WAIT_RD;
                        end else begin
                            ss_n_r  <= 1'b1;
                            state_r <= ST_GAP;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_WAIT_RD: begin
                    if (cnt_r == WAIT_LAST) begin
                        cnt_r   <= 4'd0;
                        state_r <= ST_SHIFT_IN;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_SHIFT_IN: begin
                    if (cnt_r == IN_LAST) begin
                        rd_data_r  <= {in_q_s[DATA_W-2:0], MISO};
                        rd_valid_r <= 1'b1;
                        ss_n_r     <= 1'b1;
                        cnt_r      <= 4'd0;
                        state_r    <= ST_GAP;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_r       <= 4'd0;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= 4'd0;
                    ss_n_r      <= 1'b1;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // The top shift-out bit is the MOSI register; the received MSB is consumed before it reaches bit 7
    assign unused_bits_s = ^{out_q_s[FRAME_W-2:0], in_q_s[DATA_W-1]};

    assign SS_n           = ss_n_r;
    assign MOSI           = out_q_s[FRAME_W-1];
    assign host.cmd_ready = cmd_ready_r;
    assign host.busy      = busy_r;
    assign host.rd_valid  = rd_valid_r;
    assign host.rd_data   = rd_data_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: cycle-by-cycle frame expectations plus a behavioural slave/RAM model.
module tb_spi_master_ctrl;

    localparam int RDL = 2;
    localparam int GAP = 1;

    logic clk = 1'b0;
    logic rst;
    logic ss_n, mosi, miso;
    int   total = 0;
    int   bad   = 0;
    int   cyc;

    logic [7:0] ram [256];
    logic [7:0] slave_addr;
    logic [7:0] exp_rd;

    spi_master_ctrl_if bus ();

    spi_master_ctrl #(.RD_LATENCY(RDL), .GAP_CYCLES(GAP)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (bus),
        .SS_n (ss_n),
        .MOSI (mosi),
        .MISO (miso)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One command: checks every cycle from accept to return-to-idle; abort_at>=0 leaves mid-frame
    task automatic do_frame(input logic [1:0] t, input logic [7:0] d, input bit hold, input int abort_at);
        logic [10:0] f;
        logic [7:0]  reply;
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check_eq("ready_before", 32'(bus.cmd_ready), 32'd1);
        f = {t[1], t, d};
        reply = ram[slave_addr];
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        bus.cmd_data  = d;
        tick();
        cyc = 0;
        bus.cmd_valid = hold;
        bus.cmd_type  = ~t;
        bus.cmd_data  = ~d;
        for (int k = 0; k < 11; k++) begin
            check_eq("mosi_bit", 32'(mosi), 32'(f[10-k]));
            check_eq("ssn_low", 32'(ss_n), 32'd0);
            check_eq("ready_busy", 32'(bus.cmd_ready), 32'd0);
            check_eq("busy_frame", 32'(bus.busy), 32'd1);
            miso = 1'($urandom);
            tick();
            if (cyc == abort_at) return;
        end
        check_eq("mosi_after", 32'(mosi), 32'd0);
        case (t)
            2'b00: slave_addr = d;
            2'b01: ram[slave_addr] = d;
            2'b10: slave_addr = d;
            default: reply = ram[slave_addr];
        endcase
        if (t == 2'b11) begin
            for (int w = 0; w < RDL; w++) begin
                check_eq("ssn_wait", 32'(ss_n), 32'd0);
                check_eq("mosi_wait", 32'(mosi), 32'd0);
                miso = 1'($urandom);
                tick();
                if (cyc == abort_at) return;
            end
            for (int j = 0; j < 8; j++) begin
                check_eq("ssn_shin", 32'(ss_n), 32'd0);
                check_eq("rdv_shin", 32'(bus.rd_valid), 32'd0);
                miso = reply[7-j];
                tick();
                if (cyc == abort_at) return;
            end
            exp_rd = reply;
        end
        for (int g = 0; g < GAP; g++) begin
            check_eq("ssn_gap", 32'(ss_n), 32'd1);
            check_eq("busy_gap", 32'(bus.busy), 32'd1);
            check_eq("ready_gap", 32'(bus.cmd_ready), 32'd0);
            check_eq("rd_valid", 32'(bus.rd_valid), 32'((t == 2'b11) && (g == 0)));
            miso = 1'($urandom);
            tick();
        end
        check_eq("busy_end", 32'(bus.busy), 32'd0);
        check_eq("ready_end", 32'(bus.cmd_ready), 32'd1);
        check_eq("ssn_end", 32'(ss_n), 32'd1);
        check_eq("rdv_end", 32'(bus.rd_valid), 32'd0);
        check_eq("rd_data", 32'(bus.rd_data), 32'(exp_rd));
    endtask

    task automatic apply_reset();
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            miso = 1'($urandom);
            tick();
            check_eq("rst_ssn", 32'(ss_n), 32'd1);
            check_eq("rst_mosi", 32'(mosi), 32'd0);
            check_eq("rst_ready", 32'(bus.cmd_ready), 32'd1);
            check_eq("rst_rdv", 32'(bus.rd_valid), 32'd0);
            check_eq("rst_busy", 32'(bus.busy), 32'd0);
            check_eq("rst_rdata", 32'(bus.rd_data), 32'd0);
        end
        rst = 1'b0;
        exp_rd = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        slave_addr    = 8'h00;
        exp_rd        = 8'h00;
        cyc           = 0;
        miso          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'b00;
        bus.cmd_data  = 8'h00;
        apply_reset();

        do_frame(2'b00, 8'h2A, 1'b0, -1);
        do_frame(2'b00, 8'h10, 1'b0, -1);
        do_frame(2'b01, 8'hC3, 1'b0, -1);
        do_frame(2'b10, 8'h10, 1'b0, -1);
        do_frame(2'b11, 8'h00, 1'b0, -1);
        check_eq("readback_c3", 32'(bus.rd_data), 32'h0C3);
        do_frame(2'b10, 8'h10, 1'b0, -1);
        do_frame(2'b00, 8'h55, 1'b1, -1);
        do_frame(2'b01, 8'h3C, 1'b1, -1);
        do_frame(2'b11, 8'h00, 1'b0, -1);
        check_eq("readback_3c", 32'(bus.rd_data), 32'h03C);

        do_frame(2'b01, 8'h99, 1'b0, 4);
        apply_reset();
        do_frame(2'b11, 8'h00, 1'b0, 15);
        apply_reset();

        for (int i = 0; i < 40; i++) begin
            do_frame(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), -1);
        end
        bus.cmd_valid = 1'b0;
        tick();
        check_eq("idle_ssn", 32'(ss_n), 32'd1);
        check_eq("idle_mosi", 32'(mosi), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
